// File: rtl/converter.sv
// Signed 32-bit integer times 2^exp_in to IEEE-754 single precision.
// Normalises iteratively, one left shift per clock, and then packs the result with truncation.
module converter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fixed,
    input  logic [7:0]  exp_in,
    input  logic        load_new,
    output logic [31:0] float
);

    // state | meaning
    // IDLE  | holding the last result
    // NORM  | shifting mag left until bit 31 is set (or mag is zero)
    // PACK  | assembling and writing the float word
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NORM = 2'd1;
    localparam logic [1:0] PACK = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              sign_q, sign_d;
    logic [31:0]       mag_q, mag_d;
    logic [7:0]        exp_q, exp_d;
    logic [5:0]        shcnt_q, shcnt_d;
    logic [31:0]       float_q, float_d;
    logic [31:0]       abs_fixed;
    logic signed [9:0] e_s;

    // Negating 32'h80000000 wraps back to itself, which is the correct unsigned magnitude 2^31.
    assign abs_fixed = fixed[31] ? (~fixed + 32'd1) : fixed;

    // Biased exponent: the range -1..285 fits comfortably in 10 signed bits.
    assign e_s = 10'sd158 - $signed({4'b0000, shcnt_q}) + $signed({{2{exp_q[7]}}, exp_q});

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        exp_d   = exp_q;
        shcnt_d = shcnt_q;
        float_d = float_q;
        if (load_new) begin
            sign_d  = fixed[31];
            mag_d   = abs_fixed;
            exp_d   = exp_in;
            shcnt_d = 6'd0;
            state_d = NORM;
        end else begin
            case (state_q)
                NORM: begin
                    if (mag_q == 32'd0 || mag_q[31]) begin
                        state_d = PACK;
                    end else begin
                        mag_d   = {mag_q[30:0], 1'b0};
                        shcnt_d = shcnt_q + 6'd1;
                    end
                end
                PACK: begin
                    if (mag_q == 32'd0) begin
                        float_d = 32'h0;
                    end else if (e_s >= 10'sd255) begin
                        float_d = {sign_q, 8'hFF, 23'h0};
                    end else if (e_s <= 10'sd0) begin
                        float_d = {sign_q, 31'h0};
                    end else begin
                        float_d = {sign_q, e_s[7:0], mag_q[30:8]};
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            mag_q   <= 32'd0;
            exp_q   <= 8'd0;
            shcnt_q <= 6'd0;
            float_q <= 32'h0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            shcnt_q <= shcnt_d;
            float_q <= float_d;
        end
    end

    assign float = float_q;

endmodule

// File: tb/tb_converter.sv
// Self-checking bench for converter: directed table, control sequences and a randomized run
// compared against an arithmetic reference model.
module tb_converter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fixed = 32'h0;
    logic [7:0]  exp_in = 8'h0;
    logic        load_new = 1'b0;
    logic [31:0] float;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] fx;
        logic [7:0]  ex;
        logic [31:0] want;
        string       name;
    } vec_t;

    vec_t vecs[10];

    converter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fixed    (fixed),
        .exp_in   (exp_in),
        .load_new (load_new),
        .float    (float)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, want);
        end
    endtask

    // Reference: find the leading one directly, then scale the mantissa into 24 bits.
    function automatic logic [31:0] model(input logic [31:0] f, input logic [7:0] e);
        logic   s;
        longint sf, m, fr;
        int     msb, ex, se;
        s   = f[31];
        sf  = longint'($signed(f));
        m   = (sf < 0) ? -sf : sf;
        if (m == 0) return 32'h0;
        msb = 0;
        for (int i = 0; i < 32; i++) if (m[i]) msb = i;
        se  = int'($signed(e));
        ex  = 127 + msb + se;
        if (ex >= 255) return {s, 8'hFF, 23'h0};
        if (ex <= 0) return {s, 31'h0};
        if (msb >= 23) fr = m >> (msb - 23);
        else fr = m << (23 - msb);
        return {s, ex[7:0], fr[22:0]};
    endfunction

    // Called one time unit after a rising edge; leaves the bench one time unit after the
    // 33rd edge following the load edge, which is the latest point a result may appear.
    task automatic convert(input logic [31:0] f, input logic [7:0] e);
        fixed    = f;
        exp_in   = e;
        load_new = 1'b1;
        @(posedge clk);
        #1 load_new = 1'b0;
        repeat (33) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] f, prev;
        logic [7:0]  e;

        vecs[0] = '{32'h00000001, 8'h00, 32'h3F800000, "one"};
        vecs[1] = '{32'h00000001, 8'h01, 32'h40000000, "two"};
        vecs[2] = '{32'h0000000D, 8'hFF, 32'h40D00000, "six_half"};
        vecs[3] = '{32'hFFFFFFFF, 8'h00, 32'hBF800000, "minus_one"};
        vecs[4] = '{32'h00000000, 8'h05, 32'h00000000, "zero"};
        vecs[5] = '{32'h80000000, 8'h00, 32'hCF000000, "most_neg"};
        vecs[6] = '{32'h00000001, 8'h80, 32'h00000000, "flush"};
        vecs[7] = '{32'h7FFFFFFF, 8'h7F, 32'h7F800000, "pos_inf"};
        vecs[8] = '{32'h01FFFFFF, 8'h00, 32'h4BFFFFFF, "truncate"};
        vecs[9] = '{32'h80000001, 8'h7F, 32'hFF800000, "neg_inf"};

        #1;
        check("reset_async", float, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_idle", float, 32'h0);

        foreach (vecs[i]) begin
            convert(vecs[i].fx, vecs[i].ex);
            check(vecs[i].name, float, vecs[i].want);
        end

        // Idle hold: result must not move without a new load.
        repeat (20) @(posedge clk);
        #1;
        check("idle_hold", float, 32'hFF800000);

        // Abort: the first operand must never reach the output.
        convert(32'h00000001, 8'h00);
        fixed = 32'h00000003; exp_in = 8'h00; load_new = 1'b1;
        @(posedge clk);
        #1 load_new = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_old_held", float, 32'h3F800000);
        fixed = 32'hFFFFFFFA; exp_in = 8'h02; load_new = 1'b1;
        @(posedge clk);
        #1 load_new = 1'b0;
        repeat (33) @(posedge clk);
        #1;
        check("abort_second", float, 32'hC1C00000);

        // Held strobe: only the final sample counts.
        fixed = 32'h00000005; exp_in = 8'h00; load_new = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1 fixed = fixed + 32'd1;
        end
        fixed = 32'h00000001; exp_in = 8'h00;
        @(posedge clk);
        #1 load_new = 1'b0;
        repeat (33) @(posedge clk);
        #1;
        check("held_load", float, 32'h3F800000);

        // Reset mid-conversion clears at once and suppresses the pending result.
        convert(32'h00000002, 8'h00);
        fixed = 32'h00000007; exp_in = 8'h00; load_new = 1'b1;
        @(posedge clk);
        #1 load_new = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("reset_mid_now", float, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("reset_mid_later", float, 32'h0);

        for (int n = 0; n < 200; n++) begin
            f = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) f = -f;
            if (n < 5) f = 32'h80000000 >> n;
            e = 8'($urandom);
            prev = float;
            convert(f, e);
            check("random", float, model(f, e));
            if (prev === float && model(f, e) !== prev) check("random_update", float, model(f, e));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
